// File: rtl/uart_sample_pkg.sv
// Shared types and helpers for the UART audio sample receiver.
package uart_sample_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } bit_state_t;

    localparam int unsigned METER_W = 6;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sample_rx_if.sv
// Sample output bundle: assembled PCM sample, channel tag, strobes and level meter.
interface uart_sample_rx_if
    import uart_sample_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned CW       = 1,
    parameter int unsigned CHANNELS = 2
);
    logic [W-1:0]                sample_data;
    logic [CW-1:0]               sample_chan;
    logic                        sample_valid;
    logic                        frame_error;
    logic [METER_W*CHANNELS-1:0] level;

    modport master (
        output sample_data, sample_chan, sample_valid, frame_error, level
    );

    modport slave (
        input sample_data, sample_chan, sample_valid, frame_error, level
    );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser: input synchroniser, bit FSM with glitch-rejecting
// start detection, stop-bit check and an idle-line gap counter.
module uart_byte_rx
    import uart_sample_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 31,
    parameter int unsigned GAP_BITS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       gap_timeout
);
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W    = $clog2(GAP_LIMIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rxs;
    bit_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [7:0]        shreg;
    logic [IDLE_W-1:0] idle_cnt;
    logic              at_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= HALF;
                    end
                end
                START: begin
                    if (!at_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                        cnt   <= FULL;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (!at_zero) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg[idx] <= rxs;
                        cnt        <= FULL;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (!at_zero) cnt <= cnt - 1'b1;
                    else          state <= rxs ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturates at the limit so the timeout stays asserted for the rest of the idle period.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == IDLE && rxs) begin
            if (!gap_timeout) idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    // Strobes decode the stop-bit sample cycle so the downstream registers
    // present the result exactly one clock after that sample.
    assign at_zero     = (cnt == '0);
    assign byte_valid  = (state == STOP) && at_zero && rxs;
    assign stop_err    = (state == STOP) && at_zero && !rxs;
    assign byte_data   = shreg;
    assign gap_timeout = (idle_cnt == IDLE_W'(GAP_LIMIT));

endmodule

// File: rtl/uart_sample_rx.sv
// UART PCM sample receiver: assembles bytes into interleaved multi-channel
// samples with selectable byte order and keeps a per-channel level meter.
module uart_sample_rx
    import uart_sample_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 31,
    parameter int unsigned SAMPLE_BYTES = 2,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned GAP_BITS     = 4,
    parameter int unsigned METER_SHIFT  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    uart_sample_rx_if.master smp
);
    localparam int unsigned W  = 8 * SAMPLE_BYTES;
    localparam int unsigned CW = clog2_min1(CHANNELS);
    localparam int unsigned BW = clog2_min1(SAMPLE_BYTES);
    localparam int unsigned AW = W - 1 + METER_SHIFT;

    logic [7:0]                  byte_data;
    logic                        byte_valid;
    logic                        stop_err;
    logic                        gap_timeout;
    logic [W-1:0]                word;
    logic [W-1:0]                next_word;
    logic [W-1:0]                neg_word;
    logic [BW-1:0]               bidx;
    logic [CW-1:0]               chan;
    logic                        last_byte;
    logic [W-2:0]                mag;
    logic [AW-1:0]               acc [CHANNELS];
    logic [AW-1:0]               acc_sum;
    logic [AW-1:0]               avg;
    logic [METER_SHIFT-1:0]      frames;
    logic                        window_end;
    logic [METER_W*CHANNELS-1:0] level_next;
    int unsigned                 pos;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_byte_rx (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .stop_err    (stop_err),
        .gap_timeout (gap_timeout)
    );

    always_comb begin
        pos       = (MSB_FIRST != 0) ? (SAMPLE_BYTES - 1 - 32'(bidx)) : 32'(bidx);
        next_word = word;
        next_word[8*pos +: 8] = byte_data;
        last_byte = (bidx == BW'(SAMPLE_BYTES - 1));
        neg_word  = -next_word;
        // The most negative code has no positive twin; clamp it to full scale.
        if (!next_word[W-1])            mag = next_word[W-2:0];
        else if (next_word[W-2:0] == '0) mag = '1;
        else                            mag = neg_word[W-2:0];
        acc_sum    = acc[chan] + AW'(mag);
        window_end = (chan == CW'(CHANNELS - 1)) && (frames == '1);
        avg        = '0;
        level_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            avg = ((c == 32'(chan)) ? acc_sum : acc[c]) >> METER_SHIFT;
            level_next[METER_W*c +: METER_W] = avg[W-2 -: METER_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word             <= '0;
            bidx             <= '0;
            chan             <= '0;
            frames           <= '0;
            smp.sample_data  <= '0;
            smp.sample_chan  <= '0;
            smp.sample_valid <= 1'b0;
            smp.frame_error  <= 1'b0;
            smp.level        <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) acc[c] <= '0;
        end else begin
            smp.sample_valid <= 1'b0;
            smp.frame_error  <= stop_err;
            if (stop_err || (gap_timeout && (bidx != '0 || chan != '0))) begin
                bidx <= '0;
                chan <= '0;
            end else if (byte_valid) begin
                word <= next_word;
                if (!last_byte) begin
                    bidx <= bidx + 1'b1;
                end else begin
                    bidx             <= '0;
                    chan             <= (chan == CW'(CHANNELS - 1)) ? '0 : chan + 1'b1;
                    smp.sample_data  <= next_word;
                    smp.sample_chan  <= chan;
                    smp.sample_valid <= 1'b1;
                    if (chan == CW'(CHANNELS - 1)) frames <= frames + 1'b1;
                    // The closing window includes the sample completing it.
                    if (window_end) begin
                        smp.level <= level_next;
                        for (int unsigned c = 0; c < CHANNELS; c++) acc[c] <= '0;
                    end else begin
                        acc[chan] <= acc_sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Scoreboard bench for uart_sample_rx across four parameter sets.
module tb_uart_sample_rx;
    localparam int CPB = 31;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          chan;
        logic [5:0]  lvl;
        time         t;
    } smp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1, rx2, rx3;
    smp_t exp_q[$];
    smp_t obs_q[$];
    int   fe_cnt[4];
    int   overlap = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_sample_rx_if #(.W(16), .CW(1), .CHANNELS(2)) if0 ();
    uart_sample_rx_if #(.W(24), .CW(1), .CHANNELS(1)) if1 ();
    uart_sample_rx_if #(.W(8),  .CW(1), .CHANNELS(1)) if2 ();
    uart_sample_rx_if #(.W(16), .CW(1), .CHANNELS(1)) if3 ();

    uart_sample_rx u0 (.clk(clk), .rst(rst), .uart_rx(rx0), .smp(if0));
    uart_sample_rx #(.SAMPLE_BYTES(3), .CHANNELS(1), .MSB_FIRST(1))
        u1 (.clk(clk), .rst(rst), .uart_rx(rx1), .smp(if1));
    uart_sample_rx #(.SAMPLE_BYTES(1), .CHANNELS(1))
        u2 (.clk(clk), .rst(rst), .uart_rx(rx2), .smp(if2));
    uart_sample_rx #(.CHANNELS(1), .METER_SHIFT(2))
        u3 (.clk(clk), .rst(rst), .uart_rx(rx3), .smp(if3));

    task automatic mon(input int inst, input logic v, input logic fe,
                       input logic [31:0] d, input int ch, input logic [5:0] l);
        smp_t s;
        if (v === 1'b1) begin
            s = '{inst, d, ch, l, $time};
            obs_q.push_back(s);
        end
        if (fe === 1'b1) fe_cnt[inst]++;
        if (v === 1'b1 && fe === 1'b1) overlap++;
    endtask

    always @(negedge clk) begin
        mon(0, if0.sample_valid, if0.frame_error, 32'(if0.sample_data), int'(if0.sample_chan), if0.level[5:0]);
        mon(1, if1.sample_valid, if1.frame_error, 32'(if1.sample_data), int'(if1.sample_chan), if1.level);
        mon(2, if2.sample_valid, if2.frame_error, 32'(if2.sample_data), int'(if2.sample_chan), if2.level);
        mon(3, if3.sample_valid, if3.frame_error, 32'(if3.sample_data), int'(if3.sample_chan), if3.level);
    end

    task automatic hold(input int inst, input logic v, input int clks);
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            2:       rx2 = v;
            default: rx3 = v;
        endcase
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_byte(input int inst, input logic [7:0] b, input logic stop);
        hold(inst, 1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(inst, b[i], CPB);
        hold(inst, stop, CPB);
        hold(inst, 1'b1, CPB);
    endtask

    task automatic expect_smp(input int inst, input logic [31:0] d, input int ch, input logic [5:0] l);
        smp_t s;
        s = '{inst, d, ch, l, 0};
        exp_q.push_back(s);
    endtask

    function automatic logic [5:0] meter_level(input logic [15:0] s);
        int unsigned mag;
        int unsigned avg;
        if (s == 16'h8000) mag = 32'h7FFF;
        else if (s[15])    mag = 32'h10000 - 32'(s);
        else               mag = 32'(s);
        avg = (4 * mag) >> 2;
        return 6'((avg >> 9) & 32'd63);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if0.sample_data, if0.sample_chan, if0.sample_valid, if0.frame_error, if0.level} !== '0) begin
            n_fail++;
            $display("FAIL reset_u0: got %h/%h/%b/%b/%h want all zero", if0.sample_data, if0.sample_chan, if0.sample_valid, if0.frame_error, if0.level);
        end
        n_checks++;
        if ({if1.sample_data, if1.sample_valid, if1.frame_error, if1.level} !== '0) begin
            n_fail++;
            $display("FAIL reset_u1: got %h/%b/%b/%h want all zero", if1.sample_data, if1.sample_valid, if1.frame_error, if1.level);
        end
        n_checks++;
        if ({if2.sample_data, if2.sample_valid, if2.frame_error, if2.level} !== '0) begin
            n_fail++;
            $display("FAIL reset_u2: got %h/%b/%b/%h want all zero", if2.sample_data, if2.sample_valid, if2.frame_error, if2.level);
        end
        n_checks++;
        if ({if3.sample_data, if3.sample_valid, if3.frame_error, if3.level} !== '0) begin
            n_fail++;
            $display("FAIL reset_u3: got %h/%b/%b/%h want all zero", if3.sample_data, if3.sample_valid, if3.frame_error, if3.level);
        end
    endtask

    task automatic test_stereo();
        smp_t e, o;
        expect_smp(0, 32'h1234, 0, 6'h0);
        expect_smp(0, 32'hABCD, 1, 6'h0);
        send_byte(0, 8'h34, 1'b1);
        send_byte(0, 8'h12, 1'b1);
        send_byte(0, 8'hCD, 1'b1);
        send_byte(0, 8'hAB, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stereo_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan) begin
                n_fail++;
                $display("FAIL stereo_sample: got u%0d %h ch%0d want u%0d %h ch%0d", o.inst, o.data, o.chan, e.inst, e.data, e.chan);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (if0.sample_data !== 16'hABCD || if0.sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stereo_hold: got %h valid %b want abcd valid 0", if0.sample_data, if0.sample_valid);
        end
    endtask

    task automatic test_msb_first();
        smp_t e, o;
        expect_smp(1, 32'h123456, 0, 6'h0);
        send_byte(1, 8'h12, 1'b1);
        send_byte(1, 8'h34, 1'b1);
        send_byte(1, 8'h56, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL msb_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan) begin
                n_fail++;
                $display("FAIL msb_sample: got u%0d %h ch%0d want u%0d %h ch%0d", o.inst, o.data, o.chan, e.inst, e.data, e.chan);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_glitch();
        smp_t e, o;
        time  t0;
        int   lat;
        int   fe0;
        fe0 = fe_cnt[2];
        hold(2, 1'b0, CPB / 4);
        hold(2, 1'b1, CPB);
        expect_smp(2, 32'h55, 0, 6'h0);
        t0 = $time;
        send_byte(2, 8'h55, 1'b1);
        lat = (obs_q.size() > 0) ? int'((obs_q[0].t - t0) / 10) : -1;
        n_checks++;
        if (lat < 2 + CPB / 2 + 9 * CPB - 2 || lat > 2 + CPB / 2 + 9 * CPB + 2) begin
            n_fail++;
            $display("FAIL glitch_latency: got %0d clocks want %0d +/-2", lat, 2 + CPB / 2 + 9 * CPB);
        end
        n_checks++;
        if (fe_cnt[2] != fe0) begin
            n_fail++;
            $display("FAIL glitch_frame_error: got %0d pulses want 0", fe_cnt[2] - fe0);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan) begin
                n_fail++;
                $display("FAIL glitch_sample: got u%0d %h ch%0d want u%0d %h ch%0d", o.inst, o.data, o.chan, e.inst, e.data, e.chan);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stop_error();
        smp_t e, o;
        int   fe0;
        fe0 = fe_cnt[0];
        send_byte(0, 8'h77, 1'b1);
        send_byte(0, 8'h34, 1'b0);
        hold(0, 1'b1, CPB);
        n_checks++;
        if (fe_cnt[0] - fe0 != 1) begin
            n_fail++;
            $display("FAIL stop_frame_error: got %0d pulse cycles want 1", fe_cnt[0] - fe0);
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL stop_no_strobe: got %0d strobes want 0", obs_q.size());
        end
        obs_q.delete();
        expect_smp(0, 32'h1234, 0, 6'h0);
        expect_smp(0, 32'hABCD, 1, 6'h0);
        send_byte(0, 8'h34, 1'b1);
        send_byte(0, 8'h12, 1'b1);
        send_byte(0, 8'hCD, 1'b1);
        send_byte(0, 8'hAB, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stop_resync_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan) begin
                n_fail++;
                $display("FAIL stop_resync_sample: got u%0d %h ch%0d want u%0d %h ch%0d", o.inst, o.data, o.chan, e.inst, e.data, e.chan);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_gap();
        smp_t e, o;
        expect_smp(0, 32'h1234, 0, 6'h0);
        send_byte(0, 8'h34, 1'b1);
        hold(0, 1'b1, 5 * CPB);
        send_byte(0, 8'h34, 1'b1);
        send_byte(0, 8'h12, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gap_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan) begin
                n_fail++;
                $display("FAIL gap_sample: got u%0d %h ch%0d want u%0d %h ch%0d", o.inst, o.data, o.chan, e.inst, e.data, e.chan);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_meter();
        smp_t e, o;
        for (int i = 0; i < 4; i++) begin
            expect_smp(3, 32'h8000, 0, (i == 3) ? meter_level(16'h8000) : 6'h00);
            send_byte(3, 8'h00, 1'b1);
            send_byte(3, 8'h80, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            expect_smp(3, 32'h0400, 0, (i == 3) ? meter_level(16'h0400) : meter_level(16'h8000));
            send_byte(3, 8'h00, 1'b1);
            send_byte(3, 8'h04, 1'b1);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL meter_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.inst != e.inst || o.data !== e.data || o.chan != e.chan || o.lvl !== e.lvl) begin
                n_fail++;
                $display("FAIL meter_sample: got u%0d %h lvl %h want u%0d %h lvl %h", o.inst, o.data, o.lvl, e.inst, e.data, e.lvl);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_byte();
        hold(3, 1'b0, CPB);
        hold(3, 1'b1, CPB);
        hold(3, 1'b0, CPB / 2);
        rst = 1'b1;
        hold(3, 1'b1, 3);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_strobe: got %0d strobes want 0", obs_q.size());
        end
        n_checks++;
        if (if3.level !== 6'h0 || if3.sample_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got level %h data %h want 00 0000", if3.level, if3.sample_data);
        end
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        rx3 = 1'b1;
        for (int i = 0; i < 4; i++) fe_cnt[i] = 0;
        repeat (4) @(negedge clk);
        test_reset();
        test_stereo();
        test_msb_first();
        test_glitch();
        test_stop_error();
        test_gap();
        test_meter();
        test_reset_mid_byte();
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes want 0", overlap);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
